// File: rtl/function_dispatcher.sv
// Clocked front end for the asynchronous function chooser: queues requests, issues them one-hot,
// waits for a synchronized finish and re-arms the chooser. Define FUNCTION_DISPATCHER_RR_EN for round-robin.
module function_dispatcher #(
  parameter int N          = 2,
  parameter int TIMEOUT    = 64,
  parameter int RST_CYCLES = 2,
  parameter int IDXW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_in,
  output logic [N-1:0]    ch_reqs,
  output logic            ch_rst,
  input  logic            ch_fin,
  input  logic [N-1:0]    ch_sets,
  output logic            done,
  output logic [IDXW-1:0] done_idx,
  output logic            err,
  output logic            busy
);

  localparam int CW = $clog2(TIMEOUT + RST_CYCLES) + 1;

  typedef enum logic [1:0] {ARM, IDLE, WAIT} state_t;

  state_t          state, state_n;
  logic            f1, f2, f3;
  logic [N-1:0]    sets_1, sets_s;
  logic [N-1:0]    pending;
  logic [IDXW-1:0] ptr, ptr_n;
  logic [IDXW-1:0] idx_q, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    ch_reqs_n;
  logic            ch_rst_n;
  logic            done_n, err_n;
  logic [IDXW-1:0] done_idx_n;
  logic [N-1:0]    clr_mask;
  logic            fin_rise;
  logic [IDXW-1:0] sel_idx;
  logic            sel_found;
`ifdef FUNCTION_DISPATCHER_RR_EN
  int unsigned     rr_j;
`endif

  assign fin_rise = f2 & ~f3;
  assign busy     = (state != IDLE);

  // Index selection from the pending set
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
`ifdef FUNCTION_DISPATCHER_RR_EN
    rr_j      = 0;
    for (int unsigned k = 0; k < unsigned'(N); k++) begin
      rr_j = (k + 32'(ptr)) % unsigned'(N);
      if (!sel_found && |(pending & (N'(1) << rr_j))) begin
        sel_idx   = IDXW'(rr_j);
        sel_found = 1'b1;
      end
    end
`else
    for (int unsigned k = 0; k < unsigned'(N); k++) begin
      if (!sel_found && |(pending & (N'(1) << k))) begin
        sel_idx   = IDXW'(k);
        sel_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ch_reqs_n  = ch_reqs;
    ch_rst_n   = ch_rst;
    done_n     = 1'b0;
    err_n      = 1'b0;
    done_idx_n = done_idx;
    idx_n      = idx_q;
    ptr_n      = ptr;
    clr_mask   = '0;
    case (state)
      ARM: begin
        ch_reqs_n = '0;
        ch_rst_n  = 1'b1;
        if (cnt == CW'(RST_CYCLES - 1)) begin
          ch_rst_n = 1'b0;
          cnt_n    = '0;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      IDLE: begin
        if (|pending) begin
          ch_reqs_n = N'(1) << sel_idx;
          clr_mask  = N'(1) << sel_idx;
          idx_n     = sel_idx;
          ptr_n     = (sel_idx == IDXW'(N - 1)) ? '0 : sel_idx + IDXW'(1);
          cnt_n     = '0;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        // A finish seen in the timeout cycle still counts as a completion
        if (fin_rise) begin
          done_n     = 1'b1;
          done_idx_n = idx_q;
          err_n      = (sets_s != (N'(1) << idx_q));
          ch_reqs_n  = '0;
          ch_rst_n   = 1'b1;
          cnt_n      = '0;
          state_n    = ARM;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n     = 1'b1;
          ch_reqs_n = '0;
          ch_rst_n  = 1'b1;
          cnt_n     = '0;
          state_n   = ARM;
        end
      end
      default: begin
        ch_reqs_n = '0;
        ch_rst_n  = 1'b1;
        cnt_n     = '0;
        state_n   = ARM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARM;
      f1       <= 1'b0;
      f2       <= 1'b0;
      f3       <= 1'b0;
      sets_1   <= '0;
      sets_s   <= '0;
      pending  <= '0;
      ptr      <= '0;
      idx_q    <= '0;
      cnt      <= '0;
      ch_reqs  <= '0;
      ch_rst   <= 1'b1;
      done     <= 1'b0;
      done_idx <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      f1       <= ch_fin;
      f2       <= f1;
      f3       <= f2;
      sets_1   <= ch_sets;
      sets_s   <= sets_1;
      pending  <= (pending & ~clr_mask) | req_in;
      ptr      <= ptr_n;
      idx_q    <= idx_n;
      cnt      <= cnt_n;
      ch_reqs  <= ch_reqs_n;
      ch_rst   <= ch_rst_n;
      done     <= done_n;
      done_idx <= done_idx_n;
      err      <= err_n;
    end
  end

endmodule
